rpc_delay_tuner: RTL and testbench
==================================

RPC_DELAY_TUNER -- requirements
Module: rpc_delay_tuner

Interface
REQ-001 SHALL have parameter DelayWidth, default 5, the width of the delay code driven to the programmable delay line (legal values are 1 or more).
REQ-002 SHALL have parameter SettleCycles, default 4, the number of hold cycles after each code change (legal values are 1 or more).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_valid_i  input  1  a new delay/enable request is present.
REQ-006 SHALL have port cfg_ready_o  output  1  the request is accepted on a cycle where cfg_valid_i and cfg_ready_o are both high.
REQ-007 SHALL have port cfg_delay_i  input  DelayWidth  the target delay code.
REQ-008 SHALL have port cfg_enable_i  input  1  the target enable for the delay line.
REQ-009 SHALL have port delay_o  output  DelayWidth  the current code, driven directly to the delay line delay input.
REQ-010 SHALL have port enable_o  output  1  drives the delay line enable input.
REQ-011 SHALL have port busy_o  output  1  high while a request is in progress.
REQ-012 SHALL have port done_o  output  1  a single-cycle pulse when a request completes.

Function
REQ-013 SHALL implement the FSM states IDLE, STEP and SETTLE; cfg_ready_o = (state==IDLE) && !rst_i; busy_o = (state!=IDLE).
REQ-014 On acceptance, SHALL latch cfg_delay_i into target_q and cfg_enable_i into en_q.
REQ-015 On acceptance, if cfg_enable_i==0, SHALL deassert enable_o at that edge (gate the delay line before the code moves).
REQ-016 On acceptance with target==delay_o, SHALL stay in IDLE, pulse done_o on the next cycle, set enable_o<=cfg_enable_i, and leave delay_o unchanged.
REQ-017 On acceptance with target!=delay_o, SHALL go to STEP.
REQ-018 In STEP, SHALL move delay_o one LSB toward target_q, load the settle counter with SettleCycles-1, and go to SETTLE.
REQ-019 In SETTLE with the counter nonzero, SHALL decrement the counter.
REQ-020 In SETTLE with the counter zero: if delay_o==target_q, SHALL go to IDLE, pulse done_o and set enable_o<=en_q; otherwise SHALL go to STEP.
REQ-021 Latency from the accept edge to done_o high SHALL be |target-start|*(1+SettleCycles) cycles.
REQ-022 delay_o SHALL never change by more than 1 LSB per edge, SHALL never wrap, and SHALL stay within 0..2^DelayWidth-1.
REQ-023 SHALL ignore cfg_valid_i, cfg_delay_i and cfg_enable_i while busy; a request held through busy SHALL be accepted on the first IDLE cycle, which is the cycle done_o is high.
REQ-024 done_o SHALL be high for exactly one cycle per accepted request.

Reset
REQ-025 While rst_i is high at an edge, SHALL set state=IDLE, delay_o=0, enable_o=0, done_o=0 and clear the counter, target_q and en_q.
REQ-026 Reset mid-operation SHALL abort the request with no done_o pulse; delay_o returns to 0 in one edge, which is the only permitted multi-LSB jump.

Configuration
REQ-027 Macro RPC_DELAY_TUNER_RAMP_EN SHALL select the update mode.
REQ-028 With RPC_DELAY_TUNER_RAMP_EN defined, SHALL behave as REQ-018 to REQ-022 (1-LSB ramp).
REQ-029 With RPC_DELAY_TUNER_RAMP_EN undefined, STEP SHALL load delay_o<=target_q directly, giving latency 1+SettleCycles for any nonzero distance; REQ-022 step limit waived.

Verification (DelayWidth=5, SettleCycles=4)
REQ-030 Reset, then request 5/en=1 -> delay_o steps 1,2,3,4,5, each held 5 cycles; done_o high 25 cycles after accept; enable_o rises with done_o.
REQ-031 From 5, request 2/en=0 -> enable_o low the cycle after accept; delay_o 4,3,2; done_o after 15 cycles; enable_o stays 0.
REQ-032 From 2, request 2/en=1 -> done_o high the cycle after accept, delay_o constant, enable_o=1, busy_o never high.
REQ-033 Hold cfg_valid_i with 7 during a 0->3 ramp -> cfg_ready_o low for 15 cycles; second request accepted in the done_o cycle; final delay_o=7.
REQ-034 Assert rst_i while delay_o=3 during a ramp to 9 -> next cycle delay_o=0, enable_o=0, busy_o=0, no done_o pulse.
REQ-035 Macro undefined, request 0->31 -> delay_o jumps to 31 in one edge; done_o 5 cycles after accept.

Source files
------------

// File: rtl/rpc_delay_tuner.sv
// rpc_delay_tuner: walks the code of a programmable delay line toward a requested value.
// Each code change is followed by a settle interval. The line enable is gated off before
// the code moves when the request disables it, and is restored only on completion.
//
// Build option:
//   RPC_DELAY_TUNER_RAMP_EN  defined   -> the code ramps one LSB per step
//                            undefined -> the code jumps straight to the target in one step
//
// Ports:
//   clk_i        clock; all state changes on its rising edge
//   rst_i        synchronous active-high reset
//   cfg_valid_i  request present
//   cfg_ready_o  request accepted when cfg_valid_i && cfg_ready_o
//   cfg_delay_i  target delay code
//   cfg_enable_i target delay line enable
//   delay_o      current code driven to the delay line
//   enable_o     delay line enable
//   busy_o       request in progress
//   done_o       single-cycle pulse when a request completes
module rpc_delay_tuner #(
    parameter int unsigned DelayWidth   = 5,
    parameter int unsigned SettleCycles = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [DelayWidth-1:0] cfg_delay_i,
    input  logic                  cfg_enable_i,
    output logic [DelayWidth-1:0] delay_o,
    output logic                  enable_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned CntWidth = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StStep   = 2'd1;
    localparam logic [1:0] StSettle = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DelayWidth-1:0] delay_q, delay_d;
    logic [DelayWidth-1:0] target_q, target_d;
    logic                  en_q, en_d;
    logic                  enable_q, enable_d;
    logic                  done_q, done_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        delay_d  = delay_q;
        target_d = target_q;
        en_d     = en_q;
        enable_d = enable_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            StIdle: begin
                if (cfg_valid_i) begin
                    target_d = cfg_delay_i;
                    en_d     = cfg_enable_i;
                    if (cfg_delay_i == delay_q) begin
                        done_d   = 1'b1;
                        enable_d = cfg_enable_i;
                    end else begin
                        state_d = StStep;
                        // Gate the line before the code starts to move.
                        if (!cfg_enable_i) begin
                            enable_d = 1'b0;
                        end
                    end
                end
            end
            StStep: begin
`ifdef RPC_DELAY_TUNER_RAMP_EN
                // target_q is in range, so a single LSB move can never wrap.
                if (target_q > delay_q) begin
                    delay_d = delay_q + 1'b1;
                end else begin
                    delay_d = delay_q - 1'b1;
                end
`else
                delay_d = target_q;
`endif
                cnt_d   = CntWidth'(SettleCycles - 1);
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (delay_q == target_q) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    enable_d = en_q;
                end else begin
                    state_d = StStep;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            delay_q  <= '0;
            target_q <= '0;
            en_q     <= 1'b0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            delay_q  <= delay_d;
            target_q <= target_d;
            en_q     <= en_d;
            enable_q <= enable_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cfg_ready_o = (state_q == StIdle) && !rst_i;
    assign busy_o      = (state_q != StIdle);
    assign delay_o     = delay_q;
    assign enable_o    = enable_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_rpc_delay_tuner.sv
// Testbench for rpc_delay_tuner: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level model (elapsed time since accept -> expected outputs).
module tb_rpc_delay_tuner;

    localparam int unsigned W = 5;
    localparam int unsigned S = 4;
`ifdef RPC_DELAY_TUNER_RAMP_EN
    localparam bit Ramp = 1'b1;
`else
    localparam bit Ramp = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] cfg_delay = '0;
    logic         cfg_enable = 1'b0;
    logic [W-1:0] delay;
    logic         enable;
    logic         busy;
    logic         done;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: outputs after the most recent edge plus the open transaction.
    int m_delay  = 0;
    int m_enable = 0;
    int m_busy   = 0;
    int m_done   = 0;
    int m_start, m_tgt, m_en, m_dist, m_total, m_t;
    int m_accepts = 0;

    always #5 clk = ~clk;

    rpc_delay_tuner #(
        .DelayWidth   (W),
        .SettleCycles (S)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_delay_i  (cfg_delay),
        .cfg_enable_i (cfg_enable),
        .delay_o      (delay),
        .enable_o     (enable),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after the next edge, from the request rules.
    task automatic model_edge(input logic v, input int d, input logic e, input logic r);
        int steps;
        if (r) begin
            m_delay = 0; m_enable = 0; m_busy = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_busy == 0) begin
                if (v) begin
                    m_accepts++;
                    m_start = m_delay;
                    m_tgt   = d;
                    m_en    = e;
                    m_dist  = (d > m_delay) ? d - m_delay : m_delay - d;
                    if (m_dist == 0) begin
                        m_done   = 1;
                        m_enable = e;
                    end else begin
                        m_busy  = 1;
                        m_t     = 0;
                        m_total = Ramp ? m_dist * (S + 1) : S + 1;
                        if (!e) m_enable = 0;
                    end
                end
            end else begin
                m_t++;
                if (Ramp) begin
                    steps = (m_t - 1) / (S + 1) + 1;
                    if (steps > m_dist) steps = m_dist;
                    m_delay = (m_tgt > m_start) ? m_start + steps : m_start - steps;
                end else begin
                    m_delay = m_tgt;
                end
                if (m_t == m_total) begin
                    m_busy   = 0;
                    m_done   = 1;
                    m_enable = m_en;
                end
            end
        end
    endtask

    // One clock: check outputs of the last edge, drive inputs, check ready, advance model.
    task automatic step(input logic v, input int d, input logic e, input logic r);
        @(negedge clk);
        check_eq("delay", int'(delay), m_delay);
        check_eq("enable", int'(enable), m_enable);
        check_eq("busy", int'(busy), m_busy);
        check_eq("done", int'(done), m_done);
        cfg_valid  = v;
        cfg_delay  = W'(d);
        cfg_enable = e;
        rst        = r;
        #1;
        check_eq("ready", int'(cfg_ready), (m_busy == 0 && !r) ? 1 : 0);
        model_edge(v, d, e, r);
    endtask

    task automatic run_idle(input int limit);
        int n;
        n = 0;
        while (m_busy != 0 && n < limit) begin
            step(1'b0, 0, 1'b0, 1'b0);
            n++;
        end
        check_eq("idle_bound", m_busy, 0);
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        int acc0;
        repeat (2) @(posedge clk);

        // Reset state, then 0 -> 5 enabled.
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 5, 1'b1, 1'b0);
        run_idle(400);
        check_eq("final5", int'(delay), 5);

        // 5 -> 2 disabled.
        step(1'b1, 2, 1'b0, 1'b0);
        run_idle(400);
        check_eq("final2", int'(delay), 2);
        check_eq("en_off", int'(enable), 0);

        // Same code: immediate done.
        step(1'b1, 2, 1'b1, 1'b0);
        run_idle(10);
        check_eq("en_on", int'(enable), 1);

        // Request held through busy: 0 -> 3 then 7.
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 3, 1'b1, 1'b0);
        acc0 = m_accepts;
        n = 0;
        while (m_accepts == acc0 && n < 400) begin
            step(1'b1, 7, 1'b1, 1'b0);
            n++;
        end
        check_eq("held_bound", m_accepts, acc0 + 1);
        run_idle(400);
        check_eq("final7", int'(delay), 7);

        // Reset mid-operation during a move toward 9.
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 9, 1'b1, 1'b0);
        n = 0;
        while (m_delay != 3 && m_busy != 0 && n < 400) begin
            step(1'b0, 0, 1'b0, 1'b0);
            n++;
        end
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0);
        check_eq("abort_delay", int'(delay), 0);
        step(1'b0, 0, 1'b0, 1'b0);

        // Full-scale move 0 -> 31.
        step(1'b1, 31, 1'b1, 1'b0);
        run_idle(400);
        check_eq("final31", int'(delay), 31);
        step(1'b1, 0, 1'b1, 1'b0);
        run_idle(400);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 2) == 0), int'($urandom_range(0, 31)),
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 99) == 0));
        end
        run_idle(400);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
